// File: rtl/ext_mem_responder.sv
// ext_mem_responder: single-port RAM shared by one write and one read
// requester. After reset the whole RAM is swept to zero before any request
// is granted. Afterwards a round-robin arbiter grants at most one access per
// clock. Read data returns two clocks after the grant (RAM output register,
// then output register).
module ext_mem_responder #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 11
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              wr_req_i,
    input  logic [AWIDTH-1:0] wr_addr_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    output logic              wr_ack_o,
    input  logic              rd_req_i,
    input  logic [AWIDTH-1:0] rd_addr_i,
    output logic              rd_ack_o,
    output logic              rd_valid_o,
    output logic [DWIDTH-1:0] rd_data_o,
    output logic              init_done_o
);

    localparam int DEPTH = 2 ** AWIDTH;

    typedef enum logic [1:0] {
        INIT_S    = 2'd0,
        IDLE_S    = 2'd1,
        LAST_RD_S = 2'd2,
        LAST_WR_S = 2'd3
    } state_t;

    state_t              state_reg;
    logic [AWIDTH-1:0]   sweep_reg;
    logic                init_done_reg;

    logic [DWIDTH-1:0]   mem [0:DEPTH-1];
    logic [DWIDTH-1:0]   ram_q_reg;

    logic                rd_pend_reg;
    logic                rd_valid_reg;
    logic [DWIDTH-1:0]   rd_data_reg;

    logic                wr_grant;
    logic                rd_grant;
    logic                mem_we;
    logic [AWIDTH-1:0]   mem_addr;
    logic [DWIDTH-1:0]   mem_wdata;

    // Arbitration: nothing is granted during the clear sweep; on contention
    // the requester that did not win last time gets the port.
    always_comb begin
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (state_reg != INIT_S) begin
            if (rd_req_i && wr_req_i) begin
                if (state_reg == LAST_RD_S) begin
                    wr_grant = 1'b1;
                end else begin
                    rd_grant = 1'b1;
                end
            end else begin
                rd_grant = rd_req_i;
                wr_grant = wr_req_i;
            end
        end
    end

    assign wr_ack_o = wr_grant;
    assign rd_ack_o = rd_grant;

    // Single RAM port mux: the sweep owns the port during INIT_S, otherwise
    // a granted write, otherwise the read address.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = rd_addr_i;
        mem_wdata = wr_data_i;
        if (state_reg == INIT_S) begin
            mem_we    = 1'b1;
            mem_addr  = sweep_reg;
            mem_wdata = '0;
        end else if (wr_grant) begin
            mem_we   = 1'b1;
            mem_addr = wr_addr_i;
        end
    end

    // RAM array with registered read; no reset so it maps onto block RAM.
    // While reset is held the sweep repeatedly writes zero to address 0,
    // which is harmless because the full sweep follows release.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end else if (rd_grant) begin
            ram_q_reg <= mem[mem_addr];
        end
    end

    // Control FSM: clear sweep, then track the last winner for round-robin.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_reg     <= INIT_S;
            sweep_reg     <= '0;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                INIT_S: begin
                    sweep_reg <= sweep_reg + 1'b1;
                    if (&sweep_reg) begin
                        state_reg <= IDLE_S;
                    end
                end
                default: begin
                    init_done_reg <= 1'b1;
                    if (rd_grant) begin
                        state_reg <= LAST_RD_S;
                    end else if (wr_grant) begin
                        state_reg <= LAST_WR_S;
                    end
                end
            endcase
        end
    end

    // Read return pipeline: grant -> RAM output register -> output register.
    // Reset drops any read still in flight.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rd_pend_reg  <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_pend_reg  <= rd_grant;
            rd_valid_reg <= rd_pend_reg;
            if (rd_pend_reg) begin
                rd_data_reg <= ram_q_reg;
            end
        end
    end

    assign rd_valid_o  = rd_valid_reg;
    assign rd_data_o   = rd_data_reg;
    assign init_done_o = init_done_reg;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder with a 16-word RAM: clear sweep
// timing, round-robin arbitration, write/read data path, withdrawn requests
// and mid-operation reset.
module tb_ext_mem_responder;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk;
    logic          arst;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          init_done;

    int checks = 0;
    int errors = 0;

    ext_mem_responder #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .wr_req_i    (wr_req),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_ack_o    (wr_ack),
        .rd_req_i    (rd_req),
        .rd_addr_i   (rd_addr),
        .rd_ack_o    (rd_ack),
        .rd_valid_o  (rd_valid),
        .rd_data_o   (rd_data),
        .init_done_o (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with requests asserted: nothing may be granted.
        arst    = 1'b1;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_rd_ack", 32'(rd_ack), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);

        // Release: init_done rises 17 clocks later.
        @(negedge clk);
        arst   = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            #1;
            if (c < 17) chk("init_low", 32'(init_done), 32'd0);
            else        chk("init_rise", 32'(init_done), 32'd1);
        end

        // Both requesters held from IDLE_S: rd,wr,rd,wr,... Writes go to 8..11.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rd_req  = 1'b1;
            wr_req  = 1'b1;
            rd_addr = AW'(k);
            wr_addr = AW'(8 + k / 2);
            wr_data = 16'hA000 + 16'(k / 2);
            #1;
            chk("rr_rd_ack", 32'(rd_ack), 32'((k % 2) == 0));
            chk("rr_wr_ack", 32'(wr_ack), 32'((k % 2) == 1));
        end
        @(negedge clk);
        rd_req = 1'b0;
        wr_req = 1'b0;
        #1;
        chk("idle_rd_ack", 32'(rd_ack), 32'd0);
        chk("idle_wr_ack", 32'(wr_ack), 32'd0);

        // Read back address 9 (written with 0xA001 during round-robin).
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = 4'd9;
        #1;
        chk("rd9_ack", 32'(rd_ack), 32'd1);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        chk("rd9_valid_early", 32'(rd_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("rd9_valid", 32'(rd_valid), 32'd1);
        chk("rd9_data", 32'(rd_data), 32'hA001);

        // Write 0x1234 to 5, read 5 on the very next cycle.
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = 4'd5;
        wr_data = 16'h1234;
        #1;
        chk("wr5_ack", 32'(wr_ack), 32'd1);
        @(negedge clk);
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 4'd5;
        #1;
        chk("rd5_ack", 32'(rd_ack), 32'd1);
        chk("rd5_no_wr_ack", 32'(wr_ack), 32'd0);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        chk("rd5_valid_early", 32'(rd_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("rd5_valid", 32'(rd_valid), 32'd1);
        chk("rd5_data", 32'(rd_data), 32'h1234);
        @(negedge clk);
        #1;
        chk("rd5_valid_drop", 32'(rd_valid), 32'd0);
        chk("rd5_data_hold", 32'(rd_data), 32'h1234);

        // Write 0x5555 to 6, then a write of 0xDEAD to 6 loses to a read
        // and is withdrawn; 6 must still hold 0x5555.
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = 4'd6;
        wr_data = 16'h5555;
        #1;
        chk("wr6_ack", 32'(wr_ack), 32'd1);
        @(negedge clk);
        wr_data = 16'hDEAD;
        rd_req  = 1'b1;
        rd_addr = 4'd0;
        #1;
        chk("arb_rd_wins", 32'(rd_ack), 32'd1);
        chk("arb_wr_loses", 32'(wr_ack), 32'd0);
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
        #1;
        chk("withdrawn_wr_ack", 32'(wr_ack), 32'd0);
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = 4'd6;
        #1;
        chk("rd6_ack", 32'(rd_ack), 32'd1);
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rd6_valid", 32'(rd_valid), 32'd1);
        chk("rd6_data", 32'(rd_data), 32'h5555);

        // Reset one cycle after a read grant: the read must never return.
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = 4'd5;
        #1;
        chk("pre_rst_rd_ack", 32'(rd_ack), 32'd1);
        @(negedge clk);
        rd_req = 1'b0;
        arst   = 1'b1;
        #1;
        chk("midrst_init_done", 32'(init_done), 32'd0);
        chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        arst    = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 4'd0;
        #1;
        chk("midrst_no_valid", 32'(rd_valid), 32'd0);

        // Read held through the fresh sweep: no grant until IDLE_S.
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            #1;
            chk("sweep_no_rd_ack", 32'(rd_ack), 32'd0);
            chk("sweep_no_valid", 32'(rd_valid), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("first_idle_rd_ack", 32'(rd_ack), 32'd1);
        chk("first_idle_init_low", 32'(init_done), 32'd0);

        // Back-to-back reads of all 16 addresses; everything was cleared.
        for (int c = 17; c <= 33; c++) begin
            @(negedge clk);
            if (c <= 31) rd_addr = AW'(c - 16);
            else         rd_req  = 1'b0;
            #1;
            if (c == 17) chk("reinit_rise", 32'(init_done), 32'd1);
            if (c <= 31) chk("sweep_rd_ack", 32'(rd_ack), 32'd1);
            if (c >= 18) begin
                chk("clear_valid", 32'(rd_valid), 32'd1);
                chk("clear_data", 32'(rd_data), 32'd0);
            end
        end
        @(negedge clk);
        #1;
        chk("clear_valid_drop", 32'(rd_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
